// File: rtl/arith_mult_karatsuba_out_buf.sv
// Credit-gated result buffer behind the fixed-latency Karatsuba multiplier.
// ARITH_MULT_KARATSUBA_OUT_BUF_REG_OUT_EN adds a registered output stage (counts as one of DEPTH entries).
module arith_mult_karatsuba_out_buf #(
  parameter int unsigned OP_W    = 64,
  parameter int unsigned SIDE_W  = 8,
  parameter int unsigned LATENCY = 5,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                clk,
  input  logic                a_rst_n,
  input  logic                in_avail,
  output logic                in_rdy,
  input  logic [OP_W-1:0]     in_a,
  input  logic [OP_W-1:0]     in_b,
  input  logic [SIDE_W-1:0]   in_side,
  output logic                mult_avail,
  output logic [OP_W-1:0]     mult_a,
  output logic [OP_W-1:0]     mult_b,
  output logic [SIDE_W-1:0]   mult_side,
  input  logic                mult_z_avail,
  input  logic [2*OP_W-1:0]   mult_z,
  input  logic [SIDE_W-1:0]   mult_z_side,
  output logic                out_avail,
  input  logic                out_rdy,
  output logic [2*OP_W-1:0]   out_z,
  output logic [SIDE_W-1:0]   out_side,
  output logic [1:0]          error
);

  localparam int unsigned EW  = 2*OP_W + SIDE_W;
`ifdef ARITH_MULT_KARATSUBA_OUT_BUF_REG_OUT_EN
  localparam int unsigned FD  = DEPTH - 1;
`else
  localparam int unsigned FD  = DEPTH;
`endif
  localparam int unsigned PW  = (FD > 1) ? $clog2(FD) : 1;
  localparam int unsigned FCW = $clog2(FD + 1);
  localparam int unsigned CW  = $clog2(DEPTH + 1);

  if (DEPTH < 2) begin : g_bad_depth
    $error("arith_mult_karatsuba_out_buf: DEPTH must be at least 2");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("arith_mult_karatsuba_out_buf: LATENCY must be at least 1");
  end

  logic [CW-1:0]  credit_q, credit_d;
  logic [CW-1:0]  ifl_q, ifl_d;
  logic [1:0]     err_q, err_d;
  logic [EW-1:0]  mem_q [FD];
  logic [PW-1:0]  wp_q, rp_q;
  logic [FCW-1:0] fcnt_q;
  logic [EW-1:0]  head;
  logic           issue, pop, fifo_pop, push_ok, unexp;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  assign in_rdy     = (credit_q != '0) & a_rst_n;
  assign issue      = in_avail & in_rdy;
  assign mult_avail = issue;
  assign mult_a     = in_a;
  assign mult_b     = in_b;
  assign mult_side  = in_side;
  assign pop        = out_avail & out_rdy;
  assign head       = mem_q[rp_q];
  assign error      = err_q;

  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign push_ok = mult_z_avail & ((fcnt_q != FCW'(FD)) | fifo_pop);
  assign unexp   = mult_z_avail & (ifl_q == '0) & ~issue;

  always_comb begin
    credit_d = credit_q;
    if (issue && !pop)
      credit_d = credit_q - CW'(1);
    else if (pop && !issue && credit_q != CW'(DEPTH))
      credit_d = credit_q + CW'(1);

    ifl_d = ifl_q;
    if (issue && !mult_z_avail && ifl_q != CW'(DEPTH))
      ifl_d = ifl_q + CW'(1);
    else if (mult_z_avail && !issue && ifl_q != '0)
      ifl_d = ifl_q - CW'(1);

    err_d = err_q | {unexp, mult_z_avail & ~push_ok};
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      credit_q <= CW'(DEPTH);
      ifl_q    <= '0;
      err_q    <= '0;
    end else begin
      credit_q <= credit_d;
      ifl_q    <= ifl_d;
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int unsigned i = 0; i < FD; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wp_q] <= {mult_z, mult_z_side};
        wp_q        <= ptr_inc(wp_q);
      end
      if (fifo_pop) rp_q <= ptr_inc(rp_q);
      if (push_ok && !fifo_pop)
        fcnt_q <= fcnt_q + FCW'(1);
      else if (fifo_pop && !push_ok)
        fcnt_q <= fcnt_q - FCW'(1);
    end
  end

`ifdef ARITH_MULT_KARATSUBA_OUT_BUF_REG_OUT_EN
  logic          ov_q;
  logic [EW-1:0] oreg_q;

  // Skid: the output register reloads in the same cycle it is popped.
  assign fifo_pop  = (fcnt_q != '0) & (~ov_q | out_rdy);
  assign out_avail = ov_q;
  assign {out_z, out_side} = oreg_q;

  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      ov_q   <= 1'b0;
      oreg_q <= '0;
    end else if (fifo_pop) begin
      ov_q   <= 1'b1;
      oreg_q <= head;
    end else if (pop) begin
      ov_q   <= 1'b0;
    end
  end
`else
  assign fifo_pop  = pop;
  assign out_avail = (fcnt_q != '0);
  assign {out_z, out_side} = head;
`endif

endmodule

// File: tb/tb_arith_mult_karatsuba_out_buf.sv
// Randomized bench for arith_mult_karatsuba_out_buf with an in-bench multiplier and queue-based reference model.
module tb_arith_mult_karatsuba_out_buf;
  localparam int unsigned OP_W   = 64;
  localparam int unsigned SIDE_W = 8;
  localparam int unsigned LAT    = 5;
  localparam int unsigned DEPTH  = 8;
`ifdef ARITH_MULT_KARATSUBA_OUT_BUF_REG_OUT_EN
  localparam int unsigned XL = 1;
`else
  localparam int unsigned XL = 0;
`endif

  logic              clk, a_rst_n;
  logic              in_avail, in_rdy;
  logic [OP_W-1:0]   in_a, in_b;
  logic [SIDE_W-1:0] in_side;
  logic              mult_avail;
  logic [OP_W-1:0]   mult_a, mult_b;
  logic [SIDE_W-1:0] mult_side;
  logic              mult_z_avail;
  logic [2*OP_W-1:0] mult_z;
  logic [SIDE_W-1:0] mult_z_side;
  logic              out_avail, out_rdy;
  logic [2*OP_W-1:0] out_z;
  logic [SIDE_W-1:0] out_side;
  logic [1:0]        error;

  arith_mult_karatsuba_out_buf #(
    .OP_W(OP_W), .SIDE_W(SIDE_W), .LATENCY(LAT), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n),
    .in_avail(in_avail), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_side(in_side),
    .mult_avail(mult_avail), .mult_a(mult_a), .mult_b(mult_b), .mult_side(mult_side),
    .mult_z_avail(mult_z_avail), .mult_z(mult_z), .mult_z_side(mult_z_side),
    .out_avail(out_avail), .out_rdy(out_rdy), .out_z(out_z), .out_side(out_side),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int     tests = 0;
  int     fails = 0;
  longint cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Environment multiplier: fixed-latency pipe fed from values latched at the negedge.
  logic              iss_l = 1'b0;
  logic [127:0]      z_l   = '0;
  logic [SIDE_W-1:0] s_l   = '0;
  logic              pv [LAT];
  logic [127:0]      pz [LAT];
  logic [SIDE_W-1:0] ps [LAT];
  logic              spur;
  logic [127:0]      spur_z;
  logic [SIDE_W-1:0] spur_s;

  always @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int i = 0; i < LAT; i++) begin pv[i] <= 1'b0; pz[i] <= '0; ps[i] <= '0; end
    end else begin
      pv[0] <= iss_l; pz[0] <= z_l; ps[0] <= s_l;
      for (int i = 1; i < LAT; i++) begin pv[i] <= pv[i-1]; pz[i] <= pz[i-1]; ps[i] <= ps[i-1]; end
    end
  end

  assign mult_z_avail = pv[LAT-1] | spur;
  assign mult_z       = spur ? spur_z : pz[LAT-1];
  assign mult_z_side  = spur ? spur_s : ps[LAT-1];

  // Reference model: results queue in issue order, each visible from a fixed ready cycle.
  typedef struct { logic [127:0] z; logic [SIDE_W-1:0] s; longint rdy; } ent_t;
  ent_t   q[$];
  int     m_credit = DEPTH;
  int     m_infl   = 0;
  logic [1:0] m_err = '0;
  int     n_iss = 0, n_pop = 0;
  longint last_iss_cyc = 0, last_pop_cyc = 0;
  logic [127:0]      last_pop_z = '0;
  logic [SIDE_W-1:0] last_pop_s = '0;
  int     pop_run = 0, max_run = 0;

  always @(negedge clk) begin
    if (!a_rst_n) begin
      chk("rst_in_rdy", 128'(in_rdy), 128'(0));
      chk("rst_mult_avail", 128'(mult_avail), 128'(0));
      chk("rst_out_avail", 128'(out_avail), 128'(0));
      chk("rst_error", 128'(error), 128'(0));
      chk("rst_out_z", out_z, 128'(0));
      chk("rst_out_side", 128'(out_side), 128'(0));
      q.delete();
      m_credit = DEPTH; m_infl = 0; m_err = '0; iss_l = 1'b0; pop_run = 0;
    end else begin
      bit   exp_rdy, iss, exp_av, pop;
      ent_t e;
      exp_rdy = (m_credit != 0);
      iss     = in_avail && exp_rdy;
      exp_av  = (q.size() > 0) && (q[0].rdy <= cyc);
      pop     = exp_av && out_rdy;
      chk("in_rdy", 128'(in_rdy), 128'(exp_rdy));
      chk("mult_avail", 128'(mult_avail), 128'(iss));
      chk("mult_a", 128'(mult_a), 128'(in_a));
      chk("mult_b", 128'(mult_b), 128'(in_b));
      chk("mult_side", 128'(mult_side), 128'(in_side));
      chk("out_avail", 128'(out_avail), 128'(exp_av));
      chk("error", 128'(error), 128'(m_err));
      if (exp_av) begin
        chk("out_z", out_z, q[0].z);
        chk("out_side", 128'(out_side), 128'(q[0].s));
      end

      iss_l = mult_avail;
      z_l   = 128'(mult_a) * 128'(mult_b);
      s_l   = mult_side;

      if (pop) begin
        last_pop_z = q[0].z; last_pop_s = q[0].s; last_pop_cyc = cyc;
        void'(q.pop_front());
        n_pop++;
        pop_run++;
        if (pop_run > max_run) max_run = pop_run;
      end else begin
        pop_run = 0;
      end

      if (mult_z_avail && m_infl == 0 && !iss) begin
        m_err[1] = 1'b1;
        e.z = mult_z; e.s = mult_z_side; e.rdy = cyc + 1 + XL;
        q.push_back(e);
      end
      if (iss && !mult_z_avail) m_infl++;
      else if (mult_z_avail && !iss && m_infl > 0) m_infl--;

      if (iss) begin
        e.z = 128'(in_a) * 128'(in_b); e.s = in_side; e.rdy = cyc + LAT + 1 + XL;
        q.push_back(e);
        n_iss++;
        last_iss_cyc = cyc;
      end

      if (iss && !pop) m_credit--;
      else if (pop && !iss && m_credit < DEPTH) m_credit++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    in_a    = {$urandom, $urandom};
    in_b    = {$urandom, $urandom};
    in_side = SIDE_W'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 2000;
    while (q.size() != 0 && budget > 0) begin step(); budget--; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL %s: drain timeout, %0d results still pending", name, q.size());
    end
  endtask

  initial begin
    int i0, p0, budget, ncyc;
    a_rst_n = 1'b0; in_avail = 1'b1; in_a = '0; in_b = '0; in_side = '0;
    out_rdy = 1'b0; spur = 1'b0; spur_z = '0; spur_s = '0;
    repeat (3) step();
    in_avail = 1'b0;
    a_rst_n  = 1'b1;
    step();
    chk("rel_in_rdy", 128'(in_rdy), 128'(1));

    // Single op: literal pins for product, sideband and latency.
    in_avail = 1'b1; in_a = 64'd3; in_b = 64'd7; in_side = 8'h11; out_rdy = 1'b1;
    p0 = n_pop;
    step();
    in_avail = 1'b0;
    budget = 50;
    while (n_pop == p0 && budget > 0) begin step(); budget--; end
    chk("single_latency", 128'(last_pop_cyc - last_iss_cyc), 128'(6 + XL));
    chk("single_z", last_pop_z, 128'd21);
    chk("single_side", 128'(last_pop_s), 128'h11);
    chk("single_error", 128'(error), 128'(0));
    repeat (3) step();

    // Streaming at full rate.
    i0 = n_iss; ncyc = 0; budget = 300; in_avail = 1'b1; max_run = 0;
    while (n_iss < i0 + 100 && budget > 0) begin rand_ops(); step(); ncyc++; budget--; end
    in_avail = 1'b0;
    chk("stream_issue_cycles", 128'(ncyc), 128'(100));
    wait_drain("stream");
    chk("stream_consecutive_out", 128'(max_run), 128'(100));
    repeat (3) step();

    // Back-pressure: only DEPTH credits.
    out_rdy = 1'b0; i0 = n_iss; in_avail = 1'b1;
    repeat (20) begin rand_ops(); step(); end
    chk("bp_issues", 128'(n_iss - i0), 128'(8));
    chk("bp_in_rdy", 128'(in_rdy), 128'(0));
    in_avail = 1'b0; p0 = n_pop; out_rdy = 1'b1;
    wait_drain("bp");
    chk("bp_drained", 128'(n_pop - p0), 128'(8));
    chk("bp_error", 128'(error), 128'(0));

    // Random traffic with 30% consumer readiness.
    i0 = n_iss; budget = 60000;
    while (n_iss < i0 + 10000 && budget > 0) begin
      in_avail = ($urandom_range(0, 99) < 70);
      out_rdy  = ($urandom_range(0, 99) < 30);
      rand_ops();
      step();
      budget--;
    end
    in_avail = 1'b0; out_rdy = 1'b1;
    chk("rand_issued", 128'(n_iss - i0), 128'(10000));
    wait_drain("rand");
    chk("rand_error", 128'(error), 128'(0));
    repeat (LAT + 3) step();

    // Spurious product with nothing in flight.
    spur = 1'b1; spur_z = 128'hdead_beef; spur_s = 8'h5a;
    step();
    spur = 1'b0;
    repeat (4) step();
    chk("spur_error", 128'(error), 128'h2);
    wait_drain("spur");
    repeat (10) step();
    chk("spur_sticky", 128'(error), 128'h2);

    a_rst_n = 1'b0;
    repeat (2) step();
    a_rst_n = 1'b1;
    step();
    chk("rst_clears_error", 128'(error), 128'(0));
    chk("rst_rel_in_rdy", 128'(in_rdy), 128'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
